// File: rtl/fir_err_monitor.sv
// Error monitor for the 5-tap shift-coefficient FIR: recomputes the exact output and accumulates
// |exact - approx_y| metrics over a window of 2**WIN_LOG2 valid samples. Define FIR_ERR_MSE_EN for err_sq_sum.
module fir_err_monitor #(
   parameter int W        = 16,
   parameter int WIN_LOG2 = 8,
   parameter int ACC_W    = W + WIN_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W-1:0]          x,
   input  logic [W-1:0]          approx_y,
   input  logic                  in_valid,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_W-1:0]      err_sum,
   output logic [W-1:0]          err_max,
   output logic [WIN_LOG2:0]     err_cnt
`ifdef FIR_ERR_MSE_EN
   ,
   output logic [2*W+WIN_LOG2-1:0] err_sq_sum
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [WIN_LOG2:0] CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};
   localparam logic [WIN_LOG2:0] CNT_LAST = (WIN_LOG2+1)'((2**WIN_LOG2) - 1);

   state_t              state;
   logic [W-1:0]        d1, d2, d3, d4;
   logic [W-1:0]        exact;
   logic [W-1:0]        s1_exact, s1_approx;
   logic                s1_valid;
   logic [WIN_LOG2:0]   count;
   logic signed [W:0]   diff;
   logic [W-1:0]        e;

   // The shadow delay line tracks the filter's own registers, so it never stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= '0;
         d2 <= '0;
         d3 <= '0;
         d4 <= '0;
      end else begin
         d1 <= x;
         d2 <= d1;
         d3 <= d2;
         d4 <= d3;
      end
   end

   assign exact = (x >> 5) + (d1 >> 4) + (d2 >> 3) + (d3 >> 2) + (d4 >> 1);
   assign diff  = $signed({1'b0, s1_exact}) - $signed({1'b0, s1_approx});
   assign e     = diff[W] ? W'(-diff) : W'(diff);

`ifdef FIR_ERR_MSE_EN
   logic [2*W-1:0] e_sq;
   assign e_sq = {{W{1'b0}}, e} * {{W{1'b0}}, e};
`endif

   // FLUSH is left only once stage 2 has drained, so done appears two edges after the last sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
         s1_exact   <= '0;
         s1_approx  <= '0;
         s1_valid   <= 1'b0;
         err_sum    <= '0;
         err_max    <= '0;
         err_cnt    <= '0;
`ifdef FIR_ERR_MSE_EN
         err_sq_sum <= '0;
`endif
      end else begin
         s1_exact  <= exact;
         s1_approx <= approx_y;
         s1_valid  <= 1'b0;
         if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            count      <= '0;
            err_sum    <= '0;
            err_max    <= '0;
            err_cnt    <= '0;
`ifdef FIR_ERR_MSE_EN
            err_sq_sum <= '0;
`endif
         end else begin
            if (s1_valid) begin
               err_sum <= err_sum + ACC_W'(e);
               if (e > err_max)
                  err_max <= e;
               if (e != '0)
                  err_cnt <= err_cnt + CNT_ONE;
`ifdef FIR_ERR_MSE_EN
               err_sq_sum <= err_sq_sum + (2*W+WIN_LOG2)'(e_sq);
`endif
            end
            case (state)
               IDLE: ;
               RUN: begin
                  if (in_valid) begin
                     s1_valid <= 1'b1;
                     count    <= count + CNT_ONE;
                     if (count == CNT_LAST)
                        state <= FLUSH;
                  end
               end
               FLUSH: begin
                  if (!s1_valid) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               DONE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed self-checking bench for fir_err_monitor with hand-computed expected metrics.
// Build with FIR_ERR_MSE_EN defined to also check err_sq_sum.
module tb_fir_err_monitor;

   localparam int W        = 16;
   localparam int WIN_LOG2 = 8;
   localparam int ACC_W    = W + WIN_LOG2;

   logic                clk = 1'b0;
   logic                rst;
   logic [W-1:0]        x;
   logic [W-1:0]        approx_y;
   logic                in_valid;
   logic                start;
   logic                busy;
   logic                done;
   logic [ACC_W-1:0]    err_sum;
   logic [W-1:0]        err_max;
   logic [WIN_LOG2:0]   err_cnt;
`ifdef FIR_ERR_MSE_EN
   logic [2*W+WIN_LOG2-1:0] err_sq_sum;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fir_err_monitor #(.W(W), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)) dut (
      .clk(clk),
      .rst(rst),
      .x(x),
      .approx_y(approx_y),
      .in_valid(in_valid),
      .start(start),
      .busy(busy),
      .done(done),
      .err_sum(err_sum),
      .err_max(err_max),
      .err_cnt(err_cnt)
`ifdef FIR_ERR_MSE_EN
      ,
      .err_sq_sum(err_sq_sum)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int n);
      in_valid = 1'b1;
      repeat (n) tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; x = '0; approx_y = '0; in_valid = 1'b0; start = 1'b0;
      repeat (3) tick();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err_sum !== '0) begin n_fail++; $display("[TB] FAIL reset_sum: got %0d want 0", err_sum); end
      n_cmp++; if (err_max !== '0) begin n_fail++; $display("[TB] FAIL reset_max: got %0d want 0", err_max); end
      n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", err_cnt); end
      rst = 1'b0;
      repeat (5) tick();
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_flags: got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_zero_window;
      x = '0; approx_y = '0;
      pulse_start();
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_busy: got %b want 1", busy); end
      feed(256);
      tick();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_done_early: got %b want 0", done); end
      tick();
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_done: got %b want 1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_busy_end: got %b want 0", busy); end
      n_cmp++; if (err_sum !== '0 || err_max !== '0 || err_cnt !== '0) begin n_fail++;
         $display("[TB] FAIL zero_metrics: got sum=%0d max=%0d cnt=%0d want 0 0 0", err_sum, err_max, err_cnt); end
   endtask

   task automatic test_const_error;
      x = 16'hFFFF; approx_y = 16'hF7F8;
      repeat (5) tick();
      pulse_start();
      feed(256);
      tick(); tick();
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL const_done: got %b want 1", done); end
      n_cmp++; if (err_sum !== 24'd768) begin n_fail++; $display("[TB] FAIL const_sum: got %0d want 768", err_sum); end
      n_cmp++; if (err_max !== 16'd3) begin n_fail++; $display("[TB] FAIL const_max: got %0d want 3", err_max); end
      n_cmp++; if (err_cnt !== 9'd256) begin n_fail++; $display("[TB] FAIL const_cnt: got %0d want 256", err_cnt); end
`ifdef FIR_ERR_MSE_EN
      n_cmp++; if (err_sq_sum !== 40'd2304) begin n_fail++; $display("[TB] FAIL const_sq: got %0d want 2304", err_sq_sum); end
`endif
      // valids arriving in DONE must leave the results untouched
      approx_y = 16'h0000;
      feed(10);
      n_cmp++; if (done !== 1'b1 || err_sum !== 24'd768 || err_cnt !== 9'd256) begin n_fail++;
         $display("[TB] FAIL done_hold: got done=%b sum=%0d cnt=%0d want 1 768 256", done, err_sum, err_cnt); end
   endtask

   task automatic test_single_error;
      x = 16'hFFFF; approx_y = 16'hF7FB;
      pulse_start();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++;
         $display("[TB] FAIL restart_from_done: got done=%b busy=%b want 0 1", done, busy); end
      n_cmp++; if (err_sum !== '0 || err_cnt !== '0) begin n_fail++;
         $display("[TB] FAIL clear_on_start: got sum=%0d cnt=%0d want 0 0", err_sum, err_cnt); end
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         approx_y = (i == 100) ? 16'hF800 : 16'hF7FB;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      n_cmp++; if (err_sum !== 24'd5) begin n_fail++; $display("[TB] FAIL single_sum: got %0d want 5", err_sum); end
      n_cmp++; if (err_max !== 16'd5) begin n_fail++; $display("[TB] FAIL single_max: got %0d want 5", err_max); end
      n_cmp++; if (err_cnt !== 9'd1) begin n_fail++; $display("[TB] FAIL single_cnt: got %0d want 1", err_cnt); end
`ifdef FIR_ERR_MSE_EN
      n_cmp++; if (err_sq_sum !== 40'd25) begin n_fail++; $display("[TB] FAIL single_sq: got %0d want 25", err_sq_sum); end
`endif
   endtask

   task automatic test_impulse_taps;
      // approx_y=0 exposes exact itself: 0x8000 through taps >>5,>>4,>>3,>>2,>>1
      x = '0; approx_y = '0;
      repeat (5) tick();
      pulse_start();
      in_valid = 1'b1;
      x = 16'h8000;
      tick();
      x = '0;
      repeat (255) tick();
      in_valid = 1'b0;
      tick(); tick();
      n_cmp++; if (err_sum !== 24'd31744) begin n_fail++; $display("[TB] FAIL impulse_sum: got %0d want 31744", err_sum); end
      n_cmp++; if (err_max !== 16'd16384) begin n_fail++; $display("[TB] FAIL impulse_max: got %0d want 16384", err_max); end
      n_cmp++; if (err_cnt !== 9'd5) begin n_fail++; $display("[TB] FAIL impulse_cnt: got %0d want 5", err_cnt); end
`ifdef FIR_ERR_MSE_EN
      n_cmp++; if (err_sq_sum !== 40'd357564416) begin n_fail++; $display("[TB] FAIL impulse_sq: got %0d want 357564416", err_sq_sum); end
`endif
   endtask

   task automatic test_restart_with_gaps;
      x = 16'hFFFF; approx_y = 16'hF7F8;
      repeat (5) tick();
      pulse_start();
      feed(100);
      // second start collides with a valid and with the sample still in stage 1
      in_valid = 1'b1;
      pulse_start();
      in_valid = 1'b0;
      approx_y = 16'hF7FA;
      for (int i = 0; i < 256; i++) begin
         if (i % 5 == 2) begin
            in_valid = 1'b0;
            tick();
         end
         if (i == 255) begin
            in_valid = 1'b0;
            tick(); tick(); tick();
            n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++;
               $display("[TB] FAIL restart_early_done: got done=%b busy=%b want 0 1", done, busy); end
         end
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_done: got %b want 1", done); end
      n_cmp++; if (err_sum !== 24'd256) begin n_fail++; $display("[TB] FAIL restart_sum: got %0d want 256", err_sum); end
      n_cmp++; if (err_max !== 16'd1) begin n_fail++; $display("[TB] FAIL restart_max: got %0d want 1", err_max); end
      n_cmp++; if (err_cnt !== 9'd256) begin n_fail++; $display("[TB] FAIL restart_cnt: got %0d want 256", err_cnt); end
   endtask

   task automatic test_reset_mid_window;
      x = 16'hFFFF; approx_y = 16'hF7F8;
      pulse_start();
      feed(50);
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("[TB] FAIL midrst_flags: got busy=%b done=%b want 0 0", busy, done); end
      n_cmp++; if (err_sum !== '0 || err_max !== '0 || err_cnt !== '0) begin n_fail++;
         $display("[TB] FAIL midrst_metrics: got sum=%0d max=%0d cnt=%0d want 0 0 0", err_sum, err_max, err_cnt); end
      tick();
      rst = 1'b0;
      approx_y = 16'hF7FB;
      repeat (5) tick();
      pulse_start();
      feed(256);
      tick(); tick();
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL postrst_done: got %b want 1", done); end
      n_cmp++; if (err_sum !== '0 || err_cnt !== '0) begin n_fail++;
         $display("[TB] FAIL postrst_metrics: got sum=%0d cnt=%0d want 0 0", err_sum, err_cnt); end
   endtask

   initial begin
      test_reset();
      test_zero_window();
      test_const_error();
      test_single_error();
      test_impulse_taps();
      test_restart_with_gaps();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
